// File: rtl/apurador_votos.sv
// Ballot tallying unit: one session at a time, one ballot per voter,
// registered yes/no tallies and a registered verdict once the session closes.
module apurador_votos #(
  parameter int N_ELEITORES = 3,
  parameter int W_ID = (N_ELEITORES > 1) ? $clog2(N_ELEITORES) : 1,
  parameter int W_CONT = $clog2(N_ELEITORES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abrir,
  input  logic              fechar,
  input  logic              voto_valido,
  input  logic [W_ID-1:0]   eleitor_id,
  input  logic              voto,
  output logic [W_CONT-1:0] cont_sim,
  output logic [W_CONT-1:0] cont_nao,
  output logic              aberta,
  output logic              resultado_valido,
  output logic              aprovado,
  output logic              empate,
  output logic              rejeitado
);

  typedef enum logic [1:0] {
    OCIOSA,
    ABERTA,
    APURADA
  } estado_t;

  localparam logic [W_ID:0] N_LIM = (W_ID + 1)'(N_ELEITORES);

  estado_t                estado_q, estado_d;
  logic [W_CONT-1:0]      sim_q, sim_d;
  logic [W_CONT-1:0]      nao_q, nao_d;
  logic [N_ELEITORES-1:0] votou_q, votou_d;
  logic                   rej_q, rej_d;
  logic                   apr_q, apr_d;
  logic                   emp_q, emp_d;

  logic [N_ELEITORES-1:0] sel;
  logic                   em_faixa;
  logic                   aceito;

  always_comb begin
    // Out-of-range IDs shift the one-hot off the top, leaving sel = 0.
    sel      = N_ELEITORES'(1) << eleitor_id;
    em_faixa = {1'b0, eleitor_id} < N_LIM;
    aceito   = (estado_q == ABERTA) && voto_valido && em_faixa
               && !(|(votou_q & sel));

    estado_d = estado_q;
    sim_d    = sim_q;
    nao_d    = nao_q;
    votou_d  = votou_q;
    rej_d    = voto_valido && !aceito;

    if (aceito) begin
      votou_d = votou_q | sel;
      if (voto) sim_d = sim_q + W_CONT'(1);
      else      nao_d = nao_q + W_CONT'(1);
    end

    unique case (estado_q)
      OCIOSA, APURADA: begin
        if (abrir) begin
          estado_d = ABERTA;
          sim_d    = '0;
          nao_d    = '0;
          votou_d  = '0;
        end
      end
      ABERTA: begin
        if (fechar || (&votou_q)) estado_d = APURADA;
      end
      default: estado_d = OCIOSA;
    endcase

    // Verdict is computed from the next-state tallies so it stays a flop.
    apr_d = (estado_d == APURADA) && (sim_d > nao_d);
    emp_d = (estado_d == APURADA) && (sim_d == nao_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSA;
      sim_q    <= '0;
      nao_q    <= '0;
      votou_q  <= '0;
      rej_q    <= 1'b0;
      apr_q    <= 1'b0;
      emp_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sim_q    <= sim_d;
      nao_q    <= nao_d;
      votou_q  <= votou_d;
      rej_q    <= rej_d;
      apr_q    <= apr_d;
      emp_q    <= emp_d;
    end
  end

  assign cont_sim         = sim_q;
  assign cont_nao         = nao_q;
  assign aberta           = (estado_q == ABERTA);
  assign resultado_valido = (estado_q == APURADA);
  assign aprovado         = apr_q;
  assign empate           = emp_q;
  assign rejeitado        = rej_q;

endmodule

// File: tb/tb_apurador_votos.sv
// Directed bench for apurador_votos: N=3 vector table and pattern sweep,
// plus an N=4 instance for tie and full-range sequences.
module tb_apurador_votos;

  logic       clk = 1'b0;
  logic       rst, abrir, fechar, voto_valido, voto;
  logic [1:0] eleitor_id;

  logic [1:0] sim3, nao3;
  logic       ab3, rv3, apr3, emp3, rej3;
  logic [2:0] sim4, nao4;
  logic       ab4, rv4, apr4, emp4, rej4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  apurador_votos #(.N_ELEITORES(3)) dut3 (
    .clk(clk), .rst(rst), .abrir(abrir), .fechar(fechar),
    .voto_valido(voto_valido), .eleitor_id(eleitor_id), .voto(voto),
    .cont_sim(sim3), .cont_nao(nao3), .aberta(ab3),
    .resultado_valido(rv3), .aprovado(apr3), .empate(emp3),
    .rejeitado(rej3)
  );

  apurador_votos #(.N_ELEITORES(4)) dut4 (
    .clk(clk), .rst(rst), .abrir(abrir), .fechar(fechar),
    .voto_valido(voto_valido), .eleitor_id(eleitor_id), .voto(voto),
    .cont_sim(sim4), .cont_nao(nao4), .aberta(ab4),
    .resultado_valido(rv4), .aprovado(apr4), .empate(emp4),
    .rejeitado(rej4)
  );

  // {aberta, resultado_valido, aprovado, empate, rejeitado, sim, nao}
  wire [10:0] obs3 = {ab3, rv3, apr3, emp3, rej3, 1'b0, sim3, 1'b0, nao3};
  wire [10:0] obs4 = {ab4, rv4, apr4, emp4, rej4, sim4, nao4};

  typedef struct {
    bit         r, a, f, v;
    bit [1:0]   id;
    bit         vo;
    logic [10:0] e;
  } vec_t;

  vec_t tv[$];

  function automatic logic [10:0] ex(bit ab, bit rv, bit ap, bit em,
                                     bit rj, int s, int n);
    return {ab, rv, ap, em, rj, 3'(s), 3'(n)};
  endfunction

  function automatic vec_t mk(bit r, bit a, bit f, bit v, bit [1:0] id,
                              bit vo, logic [10:0] e);
    vec_t t;
    t.r = r; t.a = a; t.f = f; t.v = v; t.id = id; t.vo = vo; t.e = e;
    return t;
  endfunction

  task automatic step(bit r, bit a, bit f, bit v, bit [1:0] id, bit vo);
    rst = r; abrir = a; fechar = f; voto_valido = v;
    eleitor_id = id; voto = vo;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [10:0] got, logic [10:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    rst = 1'b1; abrir = 0; fechar = 0; voto_valido = 0;
    eleitor_id = 0; voto = 0;

    //          r a f v id vo   ab rv ap em rj s n
    tv.push_back(mk(1,0,0,0,0,0, ex(0,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,0,1,0,1, ex(0,0,0,0,1,0,0)));
    tv.push_back(mk(0,0,1,0,0,0, ex(0,0,0,0,0,0,0)));
    tv.push_back(mk(0,1,0,0,0,0, ex(1,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,0,1,0,1, ex(1,0,0,0,0,1,0)));
    tv.push_back(mk(0,0,0,1,1,1, ex(1,0,0,0,0,2,0)));
    tv.push_back(mk(0,0,0,1,2,0, ex(1,0,0,0,0,2,1)));
    tv.push_back(mk(0,0,0,0,0,0, ex(0,1,1,0,0,2,1)));
    tv.push_back(mk(0,0,0,0,0,0, ex(0,1,1,0,0,2,1)));
    tv.push_back(mk(0,0,0,1,0,1, ex(0,1,1,0,1,2,1)));
    tv.push_back(mk(0,1,0,1,0,1, ex(1,0,0,0,1,0,0)));
    tv.push_back(mk(0,0,0,1,1,1, ex(1,0,0,0,0,1,0)));
    tv.push_back(mk(0,0,0,1,1,1, ex(1,0,0,0,1,1,0)));
    tv.push_back(mk(0,0,0,1,3,0, ex(1,0,0,0,1,1,0)));
    tv.push_back(mk(0,1,0,0,0,0, ex(1,0,0,0,0,1,0)));
    tv.push_back(mk(0,0,0,1,0,0, ex(1,0,0,0,0,1,1)));
    tv.push_back(mk(1,0,0,1,2,1, ex(0,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,0,0,0,0, ex(0,0,0,0,0,0,0)));
    tv.push_back(mk(0,1,0,0,0,0, ex(1,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,0,1,1,1, ex(1,0,0,0,0,1,0)));
    tv.push_back(mk(0,0,1,1,0,0, ex(0,1,0,1,0,1,1)));
    tv.push_back(mk(0,1,0,0,0,0, ex(1,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,1,1,0,0, ex(0,1,0,0,0,0,1)));
    tv.push_back(mk(0,0,1,0,0,0, ex(0,1,0,0,0,0,1)));
    tv.push_back(mk(0,1,0,0,0,0, ex(1,0,0,0,0,0,0)));
    tv.push_back(mk(0,0,1,0,0,0, ex(0,1,0,1,0,0,0)));

    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].a, tv[i].f, tv[i].v, tv[i].id, tv[i].vo);
      chk($sformatf("tbl[%0d]", i), obs3, tv[i].e);
    end

    // Every 3-voter pattern: verdict is the majority, tallies the popcount.
    for (int p = 0; p < 8; p++) begin
      bit [2:0] v;
      int pc;
      v  = 3'(p);
      pc = $countones(v);
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("sweep%0d_open", p), obs3, ex(1,0,0,0,0,0,0));
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 2'(k), v[k]);
      chk($sformatf("sweep%0d_last", p), obs3, ex(1,0,0,0,0,pc,3-pc));
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("sweep%0d_res", p), obs3,
          ex(0,1,(pc >= 2),0,0,pc,3-pc));
    end

    // N=4: even split closed by fechar, then a late ballot.
    step(1, 0, 0, 0, 0, 0);
    chk("n4_rst", obs4, ex(0,0,0,0,0,0,0));
    step(0, 1, 0, 0, 0, 0);
    chk("n4_open", obs4, ex(1,0,0,0,0,0,0));
    step(0, 0, 0, 1, 0, 1);
    chk("n4_id0", obs4, ex(1,0,0,0,0,1,0));
    step(0, 0, 0, 1, 1, 0);
    chk("n4_id1", obs4, ex(1,0,0,0,0,1,1));
    step(0, 0, 1, 0, 0, 0);
    chk("n4_tie", obs4, ex(0,1,0,1,0,1,1));
    step(0, 0, 0, 1, 2, 1);
    chk("n4_late", obs4, ex(0,1,0,1,1,1,1));
    step(0, 0, 0, 0, 0, 0);
    chk("n4_late_end", obs4, ex(0,1,0,1,0,1,1));

    // N=4: top ID is eligible; four ballots auto-close the session.
    step(0, 1, 0, 0, 0, 0);
    chk("n4_reopen", obs4, ex(1,0,0,0,0,0,0));
    step(0, 0, 0, 1, 3, 1);
    chk("n4_id3", obs4, ex(1,0,0,0,0,1,0));
    step(0, 0, 0, 1, 2, 1);
    chk("n4_id2", obs4, ex(1,0,0,0,0,2,0));
    step(0, 0, 0, 1, 1, 0);
    chk("n4_id1b", obs4, ex(1,0,0,0,0,2,1));
    step(0, 0, 0, 1, 0, 1);
    chk("n4_id0b", obs4, ex(1,0,0,0,0,3,1));
    step(0, 0, 0, 0, 0, 0);
    chk("n4_auto", obs4, ex(0,1,1,0,0,3,1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
